// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: row drive, 2-flop col sync, frame decode, debounce.
// Optional auto-repeat when KEYPAD_REPEAT_EN is defined.
module keypad_scanner #(
    parameter int SCAN_PERIOD   = 25_000,
    parameter int DEBOUNCE      = 4,
    parameter int REPEAT_FRAMES = 40
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       en,
    input  logic [3:0] col,
    output logic [3:0] row,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int CW = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
    localparam int DB = (DEBOUNCE < 1) ? 1 : DEBOUNCE;
    localparam int DW = $clog2(DB + 1);
    localparam logic [CW-1:0] SLOT_LAST = CW'(SCAN_PERIOD - 1);
    localparam logic [DW-1:0] DB_MAX    = DW'(DB);
    localparam logic [4:0]    NONE      = 5'h10;

    logic [3:0]      r_col_s1;
    logic [3:0]      r_col_s2;
    logic [1:0]      r_idx;
    logic [CW-1:0]   r_cnt;
    logic [2:0][3:0] r_samp;
    logic [4:0]      r_prev;
    logic [DW-1:0]   r_dcnt;
    logic [4:0]      r_stable;

    logic            w_active;
    logic            w_slot_end;
    logic            w_frame_end;
    logic [15:0]     w_frame;
    logic [4:0]      w_nlow;
    logic [3:0]      w_code;
    logic [4:0]      w_res;
    logic [DW-1:0]   w_dcnt_nx;
    logic            w_accept;
    logic            w_rep_fire;

    assign w_active    = (row != 4'hF);
    assign w_slot_end  = w_active && (r_cnt == SLOT_LAST);
    assign w_frame_end = w_slot_end && (r_idx == 2'd3);
    assign w_frame     = {r_col_s2, r_samp[2], r_samp[1], r_samp[0]};

    // Col is asynchronous to clk; two flops before any use.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_col_s1 <= 4'hF;
            r_col_s2 <= 4'hF;
        end else begin
            r_col_s1 <= col;
            r_col_s2 <= r_col_s1;
        end
    end

    // Frame decode: exactly one low bit across the 16 samples names the key.
    always_comb begin
        w_nlow = 5'd0;
        w_code = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (!w_frame[i]) begin
                w_nlow = w_nlow + 5'd1;
                w_code = 4'(i);
            end
        end
        w_res = (w_nlow == 5'd1) ? {1'b0, w_code} : NONE;
    end

    // Run length of identical frame results, saturating at the threshold.
    always_comb begin
        w_dcnt_nx = DW'(1);
        if (w_res == r_prev) begin
            w_dcnt_nx = (r_dcnt >= DB_MAX) ? r_dcnt : r_dcnt + DW'(1);
        end
        w_accept = (w_dcnt_nx >= DB_MAX) && (w_res != r_stable);
    end

`ifdef KEYPAD_REPEAT_EN
    localparam int RW = $clog2(REPEAT_FRAMES + 1);
    logic [RW-1:0] r_rep_cnt;

    assign w_rep_fire = w_frame_end && !w_accept && key_held &&
                        (r_rep_cnt == RW'(REPEAT_FRAMES - 1));

    // Count frames a key stays accepted and unchanged; wrap on each repeat.
    always_ff @(posedge clk) begin
        if (!rstn || !en) begin
            r_rep_cnt <= '0;
        end else if (w_frame_end) begin
            if (w_accept || !key_held || w_rep_fire) begin
                r_rep_cnt <= '0;
            end else begin
                r_rep_cnt <= r_rep_cnt + RW'(1);
            end
        end
    end
`else
    // Repeat period only matters when auto-repeat is built in.
    assign w_rep_fire = 1'b0 & (REPEAT_FRAMES > 0);
`endif

    // Row scan, frame sampling, debounce state and registered outputs.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            row       <= 4'hF;
            r_idx     <= 2'd0;
            r_cnt     <= '0;
            r_samp    <= '1;
            r_prev    <= NONE;
            r_dcnt    <= '0;
            r_stable  <= NONE;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else if (!en) begin
            row       <= 4'hF;
            r_idx     <= 2'd0;
            r_cnt     <= '0;
            r_prev    <= NONE;
            r_dcnt    <= '0;
            r_stable  <= NONE;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (!w_active) begin
                row <= 4'b1110;
            end else if (w_slot_end) begin
                r_cnt <= '0;
                r_idx <= r_idx + 2'd1;
                row   <= ~(4'b0001 << (r_idx + 2'd1));
                if (r_idx != 2'd3) begin
                    r_samp[r_idx] <= r_col_s2;
                end
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (w_frame_end) begin
                r_prev <= w_res;
                r_dcnt <= w_dcnt_nx;
                if (w_accept) begin
                    r_stable <= w_res;
                    if (!w_res[4]) begin
                        key_code  <= w_res[3:0];
                        key_valid <= 1'b1;
                        key_held  <= 1'b1;
                    end else begin
                        key_held <= 1'b0;
                    end
                end else if (w_rep_fire) begin
                    key_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a combinational 4x4 keypad model.
// SCAN_PERIOD=4, DEBOUNCE=3, REPEAT_FRAMES=5; frame = 16 cycles.
module tb_keypad_scanner;

    localparam int FR = 16;

    logic       clk = 1'b0;
    logic       rstn;
    logic       en;
    logic [3:0] col;
    logic [3:0] row;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic [15:0] pressed = 16'h0;
    int checks   = 0;
    int failures = 0;
    int n_pulse  = 0;
    logic [3:0] pulse_code = 4'h0;

    keypad_scanner #(
        .SCAN_PERIOD(4),
        .DEBOUNCE(3),
        .REPEAT_FRAMES(5)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .en(en),
        .col(col),
        .row(row),
        .key_code(key_code),
        .key_valid(key_valid),
        .key_held(key_held)
    );

    always #5 clk = ~clk;

    // Keypad: a pressed key pulls its column low while its row is driven.
    always_comb begin
        col = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !row[r]) col[c] = 1'b0;
    end

    always @(negedge clk) begin
        if (key_valid) begin
            n_pulse    = n_pulse + 1;
            pulse_code = key_code;
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] mask;
        int          frames;
        int          pulses;
        logic [3:0]  code;
        logic        held;
    } vec_t;

    vec_t vecs[7];

    task automatic run_seg(input string name, input logic [15:0] mask,
                           input int frames, input int pulses,
                           input logic [3:0] code, input logic held);
        int p0;
        p0 = n_pulse;
        pressed = mask;
        repeat (frames * FR) @(negedge clk);
        #1;
        chk({name, "_pulses"}, n_pulse - p0, pulses);
        chk({name, "_code"}, key_code, code);
        chk({name, "_held"}, key_held, held);
    endtask

    initial begin
        int p0;
        int rep_exp;
        vecs[0] = '{16'h0200, 5, 1, 4'h9, 1'b1};
        vecs[1] = '{16'h0000, 3, 0, 4'h9, 1'b0};
        vecs[2] = '{16'h0200, 2, 0, 4'h9, 1'b0};
        vecs[3] = '{16'h0000, 3, 0, 4'h9, 1'b0};
        vecs[4] = '{16'h0021, 5, 0, 4'h9, 1'b0};
        vecs[5] = '{16'h0001, 3, 1, 4'h0, 1'b1};
        vecs[6] = '{16'h0008, 3, 1, 4'h3, 1'b1};

        rstn = 1'b0;
        en   = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_row", row, 4'hF);
        chk("rst_code", key_code, 4'h0);
        chk("rst_valid", key_valid, 1'b0);
        chk("rst_held", key_held, 1'b0);

        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < FR; i++) begin
            logic [3:0] er;
            @(negedge clk);
            er = ~(4'b0001 << (i / 4));
            chk($sformatf("scan_row%0d", i), row, er);
        end
        @(negedge clk);
        #1;
        chk("idle_pulses", n_pulse, 0);
        chk("idle_held", key_held, 1'b0);

        for (int v = 0; v < 7; v++) begin
            run_seg($sformatf("vec%0d", v), vecs[v].mask, vecs[v].frames,
                    vecs[v].pulses, vecs[v].code, vecs[v].held);
        end

        // Key 3 held, en dropped for 10 cycles, then a fresh debounce.
        run_seg("k3_hold", 16'h0008, 2, 0, 4'h3, 1'b1);
        p0 = n_pulse;
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("enlow_%0d", i), {row, key_held}, {4'hF, 1'b0});
        end
        en = 1'b1;
        repeat (2 * FR + 1) @(negedge clk);
        #1;
        chk("en_2fr_pulses", n_pulse - p0, 0);
        repeat (FR) @(negedge clk);
        #1;
        chk("en_3fr_pulses", n_pulse - p0, 1);
        chk("en_code", pulse_code, 4'h3);
        chk("en_held", key_held, 1'b1);
        run_seg("rel3", 16'h0000, 3, 0, 4'h3, 1'b0);

        // Key 7 held 20 frames: repeats only when built in.
`ifdef KEYPAD_REPEAT_EN
        rep_exp = 4;
`else
        rep_exp = 1;
`endif
        run_seg("k7_hold", 16'h0080, 20, rep_exp, 4'h7, 1'b1);
        chk("k7_last_code", pulse_code, 4'h7);
        run_seg("rel7", 16'h0000, 3, 0, 4'h7, 1'b0);

        // Reset in the middle of a press discards the partial debounce.
        run_seg("k5_part", 16'h0020, 2, 0, 4'h7, 1'b0);
        p0 = n_pulse;
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("mrst_row", row, 4'hF);
        chk("mrst_code", key_code, 4'h0);
        chk("mrst_held", key_held, 1'b0);
        rstn = 1'b1;
        repeat (2 * FR + 1) @(negedge clk);
        #1;
        chk("mrst_2fr_pulses", n_pulse - p0, 0);
        repeat (FR) @(negedge clk);
        #1;
        chk("mrst_3fr_pulses", n_pulse - p0, 1);
        chk("mrst_code5", key_code, 4'h5);
        chk("mrst_held5", key_held, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
